// File: rtl/round_sequencer.sv
// Game-flow controller: new target -> show -> keypad entry -> check -> result, tracking score and lives.
// Optional LEVEL_SPEEDUP_EN: show time halves every 4 points of score, down to 1/8.
module round_sequencer #(
    parameter int unsigned SHOW_CYCLES    = 500000000,
    parameter int unsigned RESULT_CYCLES  = 200000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned MAX_LIVES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_valid,
    input  logic [3:0]  key_value,
    input  logic [15:0] target,
    output logic        new_target,
    output logic [2:0]  phase,
    output logic [15:0] entry,
    output logic [2:0]  entry_count,
    output logic        correct,
    output logic [7:0]  score,
    output logic [1:0]  lives
);
    localparam int unsigned MAX_A   = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
    localparam int unsigned MAX_DUR = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int          CW      = $clog2(MAX_DUR);

    localparam logic [CW-1:0] SHOW_LEN    = CW'(SHOW_CYCLES);
    localparam logic [CW-1:0] RESULT_LAST = CW'(RESULT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHOW   = 3'd1,
        S_INPUT  = 3'd2,
        S_CHECK  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] show_len_q;
    logic          start_q;
    logic          new_target_q;
    logic [15:0]   entry_q;
    logic [2:0]    entry_count_q;
    logic [15:0]   target_q;
    logic          correct_q;
    logic [7:0]    score_q;
    logic [1:0]    lives_q;

    logic start_edge_d;
    logic digit_ok_d;
    logic input_done_d;

`ifdef LEVEL_SPEEDUP_EN
    // Shift saturates at 3; a zero-length show is bumped to one cycle.
    function automatic logic [CW-1:0] show_len_for(input logic [7:0] sc);
        logic [1:0]    sh;
        logic [CW-1:0] len;
        sh  = (sc[7:2] > 6'd3) ? 2'd3 : sc[3:2];
        len = SHOW_LEN >> sh;
        return (len == '0) ? CW'(1) : len;
    endfunction
`endif

    assign start_edge_d = start & ~start_q;
    assign digit_ok_d   = key_valid && (key_value <= 4'd9) && (entry_count_q < 3'd4);
    // A 4th digit landing on the timeout cycle is still accepted, so the check sees it.
    assign input_done_d = (digit_ok_d && entry_count_q == 3'd3) || (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            show_len_q    <= SHOW_LEN;
            start_q       <= 1'b0;
            new_target_q  <= 1'b0;
            entry_q       <= '0;
            entry_count_q <= '0;
            target_q      <= '0;
            correct_q     <= 1'b0;
            score_q       <= '0;
            lives_q       <= 2'(MAX_LIVES);
        end else begin
            start_q      <= start;
            new_target_q <= 1'b0;
            cnt_q        <= cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_edge_d) begin
                        new_target_q  <= 1'b1;
                        show_len_q    <= SHOW_LEN;
                        entry_q       <= '0;
                        entry_count_q <= '0;
                        state_q       <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == '0) target_q <= target;
                    if (cnt_q == show_len_q - CW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= S_INPUT;
                    end
                end
                S_INPUT: begin
                    if (digit_ok_d) begin
                        entry_q       <= {entry_q[11:0], key_value};
                        entry_count_q <= entry_count_q + 3'd1;
                    end else if (key_valid && key_value == 4'hC) begin
                        entry_q       <= '0;
                        entry_count_q <= '0;
                    end
                    if (input_done_d) begin
                        cnt_q   <= '0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt_q <= '0;
                    if (entry_count_q == 3'd4 && entry_q == target_q) begin
                        correct_q <= 1'b1;
                        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                    end else begin
                        correct_q <= 1'b0;
                        if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
                    end
                    state_q <= S_RESULT;
                end
                S_RESULT: begin
                    if (cnt_q == RESULT_LAST) begin
                        cnt_q <= '0;
                        if (lives_q == 2'd0) begin
                            state_q <= S_OVER;
                        end else begin
                            new_target_q  <= 1'b1;
                            entry_q       <= '0;
                            entry_count_q <= '0;
`ifdef LEVEL_SPEEDUP_EN
                            show_len_q    <= show_len_for(score_q);
`else
                            show_len_q    <= SHOW_LEN;
`endif
                            state_q       <= S_SHOW;
                        end
                    end
                end
                S_OVER: begin
                    cnt_q <= '0;
                    if (start_edge_d) begin
                        score_q       <= '0;
                        lives_q       <= 2'(MAX_LIVES);
                        correct_q     <= 1'b0;
                        new_target_q  <= 1'b1;
                        entry_q       <= '0;
                        entry_count_q <= '0;
                        show_len_q    <= SHOW_LEN;
                        state_q       <= S_SHOW;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign new_target  = new_target_q;
    assign phase       = state_q;
    assign entry       = entry_q;
    assign entry_count = entry_count_q;
    assign correct     = correct_q;
    assign score       = score_q;
    assign lives       = lives_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: table of rounds plus hand sequences for restart, reset and speedup.
module tb_round_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic [15:0] target = 16'h0;
    logic        new_target;
    logic [2:0]  phase;
    logic [15:0] entry;
    logic [2:0]  entry_count;
    logic        correct;
    logic [7:0]  score;
    logic [1:0]  lives;

    round_sequencer #(
        .SHOW_CYCLES(10), .RESULT_CYCLES(5), .TIMEOUT_CYCLES(50), .MAX_LIVES(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_value(key_value),
        .target(target), .new_target(new_target), .phase(phase), .entry(entry),
        .entry_count(entry_count), .correct(correct), .score(score), .lives(lives)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] tgt;
        logic [31:0] keys;      // first key in [31:28]
        logic [3:0]  nkeys;
        logic        late;      // last key lands on the final INPUT cycle
        logic [15:0] exp_entry;
        logic [2:0]  exp_count;
        logic        exp_correct;
    } round_t;

    typedef struct packed {
        logic [15:0] entry;
        logic [2:0]  count;
        logic        correct;
        logic [7:0]  score;
        logic [1:0]  lives;
    } exp_t;

    exp_t   sb_q[$];
    round_t vecs[7];
    int     n_checks = 0;
    int     n_fail = 0;
    int     m_score = 0;
    int     m_lives = 3;
    int     round_no = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_show();
        int len;
        len = 10;
`ifdef LEVEL_SPEEDUP_EN
        begin
            int sh;
            sh = m_score / 4;
            if (sh > 3) sh = 3;
            len = 10 >> sh;
        end
`endif
        return len;
    endfunction

    // Entered on the first SHOW sample; leaves on the first INPUT sample.
    task automatic do_show(input int exp_len, input bit poke);
        int n;
        n = 1;
        chk("show_new_target", {31'd0, new_target}, 32'd1);
        chk("show_phase", {29'd0, phase}, 32'd1);
        for (int g = 1; g < 500; g++) begin
            key_valid = poke && (n == 2);
            key_value = 4'd5;
            tick();
            if (g == 1) chk("new_target_pulse", {31'd0, new_target}, 32'd0);
            if (phase != 3'd1) break;
            n++;
        end
        key_valid = 1'b0;
        chk("show_len", n, exp_len);
        chk("input_enter", {29'd0, phase}, 32'd2);
        chk("show_keys_ignored", {29'd0, entry_count}, 32'd0);
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_value = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_input(input round_t r, output int inp_n);
        logic [3:0] k;
        inp_n = 1;
        for (int i = 0; i < int'(r.nkeys); i++) begin
            k = r.keys[31 - 4*i -: 4];
            if (r.late && i == int'(r.nkeys) - 1) begin
                for (int g = 0; g < 200 && inp_n < 50 && phase == 3'd2; g++) begin
                    tick();
                    if (phase == 3'd2) inp_n++;
                end
            end
            press(k);
            if (phase != 3'd2) break;
            inp_n++;
            tick();
            if (phase != 3'd2) break;
            inp_n++;
        end
        for (int g = 0; g < 200 && phase == 3'd2; g++) begin
            tick();
            if (phase == 3'd2) inp_n++;
        end
    endtask

    task automatic do_check_result();
        exp_t e;
        int   n;
        chk("check_phase", {29'd0, phase}, 32'd3);
        tick();
        chk("check_one_cycle", {29'd0, phase}, 32'd4);
        e = sb_q.pop_front();
        chk("entry", {16'd0, entry}, {16'd0, e.entry});
        chk("entry_count", {29'd0, entry_count}, {29'd0, e.count});
        chk("correct", {31'd0, correct}, {31'd0, e.correct});
        chk("score", {24'd0, score}, {24'd0, e.score});
        chk("lives", {30'd0, lives}, {30'd0, e.lives});
        $display("round %0d: target=%h entry=%h count=%0d correct=%0d score=%0d lives=%0d",
                 round_no, target, entry, entry_count, correct, score, lives);
        n = 1;
        for (int g = 0; g < 200; g++) begin
            start = (n == 2);
            tick();
            if (phase != 3'd4) break;
            n++;
        end
        start = 1'b0;
        chk("result_len", n, 5);
        if (e.lives != 2'd0) begin
            chk("next_show", {29'd0, phase}, 32'd1);
        end else begin
            chk("over_phase", {29'd0, phase}, 32'd5);
            chk("over_no_request", {31'd0, new_target}, 32'd0);
        end
    endtask

    task automatic run_round(input round_t r);
        exp_t e;
        int   inp_n;
        target = r.tgt;
        do_show(exp_show(), 1'b1);
        if (r.exp_correct) begin
            if (m_score < 255) m_score++;
        end else if (m_lives > 0) begin
            m_lives--;
        end
        e.entry   = r.exp_entry;
        e.count   = r.exp_count;
        e.correct = r.exp_correct;
        e.score   = 8'(m_score);
        e.lives   = 2'(m_lives);
        sb_q.push_back(e);
        do_input(r, inp_n);
        if (r.exp_count != 3'd4 || r.late) chk("input_timeout_len", inp_n, 50);
        do_check_result();
        round_no++;
    endtask

    task automatic start_edge();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        round_t r;
        vecs[0] = '{16'h4721, 32'h4721_0000, 4'd4, 1'b0, 16'h4721, 3'd4, 1'b1};
        vecs[1] = '{16'h4721, 32'h47C2_1390, 4'd7, 1'b0, 16'h2139, 3'd4, 1'b0};
        vecs[2] = '{16'h1234, 32'h1234_0000, 4'd4, 1'b1, 16'h1234, 3'd4, 1'b1};
        vecs[3] = '{16'h9999, 32'h999F_0000, 4'd4, 1'b0, 16'h0999, 3'd3, 1'b0};
        vecs[4] = '{16'h5555, 32'h5555_0000, 4'd4, 1'b0, 16'h5555, 3'd4, 1'b1};
        vecs[5] = '{16'h0000, 32'h0000_0000, 4'd4, 1'b0, 16'h0000, 3'd4, 1'b1};
        vecs[6] = '{16'h8888, 32'h0000_0000, 4'd0, 1'b0, 16'h0000, 3'd0, 1'b0};

        repeat (3) tick();
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_new_target", {31'd0, new_target}, 32'd0);
        chk("rst_entry", {16'd0, entry}, 32'd0);
        chk("rst_count", {29'd0, entry_count}, 32'd0);
        chk("rst_correct", {31'd0, correct}, 32'd0);
        chk("rst_score", {24'd0, score}, 32'd0);
        chk("rst_lives", {30'd0, lives}, 32'd3);
        rst = 1'b1;
        repeat (2) tick();
        chk("idle_hold", {29'd0, phase}, 32'd0);
        start_edge();

        for (int i = 0; i < 7; i++) run_round(vecs[i]);

        repeat (3) tick();
        chk("over_hold_phase", {29'd0, phase}, 32'd5);
        chk("over_hold_lives", {30'd0, lives}, 32'd0);
        chk("over_hold_score", {24'd0, score}, 32'd4);
        chk("over_hold_correct", {31'd0, correct}, 32'd0);
        start_edge();
        m_score = 0;
        m_lives = 3;
        chk("restart_score", {24'd0, score}, 32'd0);
        chk("restart_lives", {30'd0, lives}, 32'd3);
        chk("restart_correct", {31'd0, correct}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            r.tgt = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            r.keys        = {r.tgt, 16'h0};
            r.nkeys       = 4'd4;
            r.late        = 1'b0;
            r.exp_entry   = r.tgt;
            r.exp_count   = 3'd4;
            r.exp_correct = 1'b1;
            run_round(r);
        end

        do_show(exp_show(), 1'b0);
        press(4'd3);
        tick();
        press(4'd8);
        chk("pre_reset_count", {29'd0, entry_count}, 32'd2);
        chk("pre_reset_entry", {16'd0, entry}, 32'h0038);
        chk("pre_reset_score", {24'd0, score}, 32'd12);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_score = 0;
        m_lives = 3;
        chk("midrst_phase", {29'd0, phase}, 32'd0);
        chk("midrst_entry", {16'd0, entry}, 32'd0);
        chk("midrst_count", {29'd0, entry_count}, 32'd0);
        chk("midrst_score", {24'd0, score}, 32'd0);
        chk("midrst_lives", {30'd0, lives}, 32'd3);
        tick();
        chk("midrst_idle", {29'd0, phase}, 32'd0);

        start_edge();
        for (int i = 0; i < 3; i++) run_round(vecs[6]);
        start_edge();
        chk("final_restart_phase", {29'd0, phase}, 32'd1);
        chk("final_restart_req", {31'd0, new_target}, 32'd1);
        chk("final_restart_score", {24'd0, score}, 32'd0);
        chk("final_restart_lives", {30'd0, lives}, 32'd3);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
